dcpu16_run_ctrl: RTL

DCPU16_RUN_CTRL -- requirements
Module: dcpu16_run_ctrl

---
 rtl/dcpu16_ctrl_pkg.sv | 43 ++++
 rtl/sat_counter.sv | 21 ++
 rtl/dcpu16_run_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dcpu16_ctrl_pkg.sv
// DCPU-16 run controller shared types.
// States, host commands, halt causes and counter helpers.
package dcpu16_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_STEP  = 2'd1,
    OP_HALT  = 2'd2,
    OP_CLEAR = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    HR_NONE     = 3'd0,
    HR_ILLEGAL  = 3'd1,
    HR_SUCCESS  = 3'd2,
    HR_WATCHDOG = 3'd3,
    HR_BREAK    = 3'd4,
    HR_USER     = 3'd5,
    HR_STEP     = 3'd6
  } halt_reason_e;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  localparam logic [15:0] SUCCESS_CODE_DEF = 16'h3FF0;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit saturating counter.
// Clear wins over increment; sticks at all-ones.
module sat_counter
  import dcpu16_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  // count up until full, never wrap
  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/dcpu16_run_ctrl.sv
// DCPU-16 run controller.
// Issues single steps to the core and decides when to halt.
module dcpu16_run_ctrl
  import dcpu16_ctrl_pkg::*;
#(
  parameter logic [31:0] WDOG_LIMIT   = 32'd100000,
  parameter logic [15:0] SUCCESS_CODE = SUCCESS_CODE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        bp_enable,
  input  logic [15:0] bp_addr,
  output logic        core_step,
  input  logic        core_done,
  input  logic [15:0] core_pc,
  input  logic [15:0] core_instr,
  input  logic        core_illegal,
  output logic [1:0]  state,
  output logic [2:0]  halt_reason,
  output logic [31:0] retired_count,
  output logic [31:0] cycle_count
);

  state_e       st;
  halt_reason_e why;
  halt_reason_e cause;
  mode_e        mode;
  logic         pend;
  logic         stopped;
  logic         active;
  logic         retire;
  logic         cnt_clr;
  logic         halt_cmd;
  logic         go_cmd;
  logic [31:0]  ret_nxt;

  assign cmd_ready   = 1'b1;
  assign state       = st;
  assign halt_reason = why;

  assign stopped  = (st == ST_IDLE) || (st == ST_HALTED);
  assign active   = !stopped;
  assign retire   = (st == ST_WAIT) && core_done;
  assign halt_cmd = cmd_valid && (cmd_op == OP_HALT);
  assign go_cmd   = cmd_valid &&
                    ((cmd_op == OP_RUN) ||
                     (cmd_op == OP_STEP));
  assign cnt_clr  = stopped && cmd_valid &&
                    (cmd_op == OP_CLEAR);
  assign ret_nxt  = sat_inc(retired_count);

  // halt cause of the retiring instruction, highest first
  always_comb begin
    cause = HR_NONE;
    if (core_illegal) begin
      if (core_instr == SUCCESS_CODE)
        cause = HR_SUCCESS;
      else
        cause = HR_ILLEGAL;
    end else if (WDOG_LIMIT != '0 &&
                 ret_nxt == WDOG_LIMIT)
      cause = HR_WATCHDOG;
    else if (bp_enable && core_pc == bp_addr)
      cause = HR_BREAK;
    else if (pend)
      cause = HR_USER;
    else if (mode == MODE_STEP)
      cause = HR_STEP;
  end

  sat_counter u_retired (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (retire),
    .count (retired_count)
  );

  sat_counter u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (active),
    .count (cycle_count)
  );

  // run-control FSM; core_step is high exactly in ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_IDLE;
      core_step <= 1'b0;
      why       <= HR_NONE;
      pend      <= 1'b0;
      mode      <= MODE_RUN;
    end else begin
      core_step <= 1'b0;
      unique case (st)
        ST_IDLE, ST_HALTED: begin
          if (go_cmd) begin
            st        <= ST_ISSUE;
            core_step <= 1'b1;
            why       <= HR_NONE;
            if (cmd_op == OP_STEP)
              mode <= MODE_STEP;
            else
              mode <= MODE_RUN;
          end else if (cnt_clr) begin
            st  <= ST_IDLE;
            why <= HR_NONE;
          end
        end
        ST_ISSUE: begin
          st <= ST_WAIT;
          if (halt_cmd)
            pend <= 1'b1;
        end
        ST_WAIT: begin
          if (core_done) begin
            if (cause != HR_NONE) begin
              st   <= ST_HALTED;
              why  <= cause;
              pend <= 1'b0;
            end else begin
              st        <= ST_ISSUE;
              core_step <= 1'b1;
              if (halt_cmd)
                pend <= 1'b1;
            end
          end else if (halt_cmd) begin
            pend <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
